// File: rtl/lsu_axi_lite.sv
// Load/store unit bridging the core memory stage to an AXI4-Lite data bus.
// One request in flight; sub-word lane alignment, load extension, error/timeout status.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// RD_ADDR | AR channel valid, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// WR_REQ  | AW and W valids outstanding, each dropped on its own handshake
// WR_RESP | bready high, waiting for bvalid
// DONE    | resp_valid pulse, back to IDLE
module lsu_axi_lite #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [1:0]          resp_err,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [2:0]          axi_arprot,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [XLEN-1:0]     axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [2:0]          axi_awprot,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [XLEN-1:0]     axi_wdata,
    output logic [XLEN/8-1:0]   axi_wstrb,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS   = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    // Wait timer counts down from TIMEOUT-1; terminal count is zero.
    localparam logic [31:0] TMO_LOAD = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [2:0]         state_q, state_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [OFFW-1:0]    off_q, off_d;
    logic [31:0]        wait_cnt_q, wait_cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_rdata_q, resp_rdata_d;
    logic [1:0]         resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic               awvalid_q, awvalid_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [NBYTES-1:0]  wstrb_q, wstrb_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;

    logic [2:0]         align_mask;
    logic               misalign;
    logic [OFFW-1:0]    req_off;
    logic [ADDR_W-1:0]  bus_addr;
    logic [NBYTES-1:0]  strb_base;
    logic [XLEN-1:0]    rd_shift;
    logic [XLEN-1:0]    lane_mask;
    logic               sign_bit;
    logic [XLEN-1:0]    load_ext;
    logic               tmo_hit;
    logic               abort;
    logic               aw_pending;
    logic               w_pending;

    assign req_ready = (state_q == IDLE) && !rst;

    assign align_mask = 3'((4'd1 << req_size) - 4'd1);
    assign misalign   = (|(req_addr[2:0] & align_mask)) || ((req_size == 2'd3) && (XLEN == 32));
    assign req_off    = req_addr[OFFW-1:0];
    assign bus_addr   = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign strb_base  = ~({NBYTES{1'b1}} << (4'd1 << req_size));

    // Sign bit is the top bit of the lane mask, isolated by mask ^ (mask >> 1).
    assign rd_shift  = axi_rdata >> {off_q, 3'b000};
    assign lane_mask = ~({XLEN{1'b1}} << (7'd8 << size_q));
    assign sign_bit  = !unsigned_q && (|(rd_shift & (lane_mask ^ (lane_mask >> 1))));
    assign load_ext  = (rd_shift & lane_mask) | (sign_bit ? ~lane_mask : {XLEN{1'b0}});

    assign tmo_hit    = (TIMEOUT > 0) && (wait_cnt_q == 32'd0);
    assign aw_pending = awvalid_q && !axi_awready;
    assign w_pending  = wvalid_q && !axi_wready;

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        off_d        = off_q;
        wait_cnt_d   = (wait_cnt_q != 32'd0) ? wait_cnt_q - 32'd1 : 32'd0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    off_d      = req_off;
                    wait_cnt_d = TMO_LOAD;
                    if (misalign) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_ALIGN;
                        resp_rdata_d = '0;
                        state_d      = DONE;
                    end else if (req_we) begin
                        awaddr_d  = bus_addr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        wdata_d   = req_wdata << {req_off, 3'b000};
                        wstrb_d   = strb_base << req_off;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = bus_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (axi_arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    wait_cnt_d = TMO_LOAD;
                    state_d    = RD_DATA;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            RD_DATA: begin
                if (axi_rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                    if (axi_rresp != 2'b00) begin
                        resp_err_d   = ERR_BUS;
                        resp_rdata_d = '0;
                    end else begin
                        resp_err_d   = ERR_OK;
                        resp_rdata_d = load_ext;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            WR_REQ: begin
                if (!aw_pending && !w_pending) begin
                    awvalid_d  = 1'b0;
                    wvalid_d   = 1'b0;
                    bready_d   = 1'b1;
                    wait_cnt_d = TMO_LOAD;
                    state_d    = WR_RESP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    awvalid_d = aw_pending;
                    wvalid_d  = w_pending;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = (axi_bresp != 2'b00) ? ERR_BUS : ERR_OK;
                    state_d      = DONE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A timed-out transaction is abandoned; late bus responses are ignored in IDLE.
        if (abort) begin
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_TMO;
            resp_rdata_d = '0;
            state_d      = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            off_q        <= '0;
            wait_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            off_q        <= off_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign axi_araddr  = araddr_q;
    assign axi_arprot  = 3'b000;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awprot  = 3'b000;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;

endmodule

// File: doc/lsu_axi_lite.md
# lsu_axi_lite

Parametrised load/store unit that sits between the core's memory stage and the AXI4-Lite data bus. It replaces the inline MEM-stage read/write sequencing. It accepts one request at a time over a valid/ready port and aligns sub-word stores into byte lanes. It sign- or zero-extends loads, handles the AW/W channels independently, and reports misalignment, bus-error and timeout status.

## Interface
- XLEN, 32: data and AXI data width; 32 or 64.
- ADDR_W, 32: address width.
- TIMEOUT, 0: maximum cycles waited in any single bus wait state; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (legal only when XLEN=64).
- req_unsigned  in  1  zero-extend the load (lbu/lhu/lwu).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  2  0 ok, 1 misaligned/illegal size, 2 bus error, 3 timeout.
- axi_araddr/axi_arprot/axi_arvalid  out  ADDR_W/3/1; axi_arready  in  1.
- axi_rdata  in  XLEN; axi_rresp  in  2; axi_rvalid  in  1; axi_rready  out  1.
- axi_awaddr/axi_awprot/axi_awvalid  out  ADDR_W/3/1; axi_awready  in  1.
- axi_wdata  out  XLEN; axi_wstrb  out  XLEN/8; axi_wvalid  out  1; axi_wready  in  1.
- axi_bresp  in  2; axi_bvalid  in  1; axi_bready  out  1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- req_ready = 1 only in IDLE with rst low. A request is accepted on req_valid && req_ready, and addr, size, we, unsigned and wdata are latched.
- Let OFF = req_addr[log2(XLEN/8)-1:0] and NB = 1<<req_size.
- Misaligned: (req_addr mod NB) != 0, or req_size=3 with XLEN=32. The unit goes IDLE→DONE with resp_err=1 and issues no bus traffic.
- Bus address = req_addr with the low log2(XLEN/8) bits cleared. arprot = awprot = 3'b000.
- Load: IDLE→RD_ADDR, where arvalid=1 is held until arready. On that handshake arvalid=0, rready=1, → RD_DATA. On rvalid, rready=0, → DONE.
  - resp_rdata = NB bytes taken from axi_rdata at lane OFF, sign-extended unless req_unsigned.
  - rresp != 0 → resp_err=2, resp_rdata=0.
- Store: IDLE→WR_REQ with awvalid=1 and wvalid=1 asserted together.
  - wstrb = ((1<<NB)-1) << OFF; wdata = req_wdata << (8*OFF).
  - awvalid and wvalid each drop independently on their own handshake, in either order or in the same cycle.
  - When both handshakes are complete, bready=1 → WR_RESP. On bvalid, bready=0 → DONE.
  - bresp != 0 → resp_err=2.
- Timeout (TIMEOUT>0): a wait counter clears on entry to RD_ADDR, RD_DATA, WR_REQ and WR_RESP, and increments every cycle spent there. When it reaches TIMEOUT, all AXI valid/ready outputs drop, resp_err=3, → DONE. This is an abort for bring-up and debug only; late bus responses after it are ignored.
- DONE: resp_valid=1 for exactly one cycle, → IDLE. resp_rdata and resp_err hold their values until the next DONE.

## Timing
- Reset values: state IDLE; req_ready 0 while rst high; resp_valid, resp_rdata, resp_err, all AXI valid/ready outputs, addresses, wdata and wstrb are 0.
- rst asserted mid-transaction: at the next edge every AXI valid/ready output is 0, state is IDLE and no resp_valid is produced.
- Accept at edge 0:
  - Zero-wait load: arvalid high in cycle 1, rready high in cycle 2, resp_valid in cycle 3.
  - Zero-wait store: aw/w valid in cycle 1, bready in cycle 2, resp_valid in cycle 3.
  - Misaligned: resp_valid in cycle 1.
- Back-to-back: the next request can be accepted in the cycle after resp_valid.
- AXI outputs are registered. A valid signal never drops before its handshake, except on timeout or reset.

## Test plan
- Load, XLEN=32: addr 0x1003, size 0, signed; bus returns rdata 0x80FF_FF7F with the bus address 0x1000 → resp_rdata 0xFFFF_FF80, err 0, resp_valid 3 cycles after accept with zero-wait slave.
- Store half: addr 0x2002, wdata 0x1234_ABCD → awaddr 0x2000, wstrb 4'b1100, wdata 0xABCD_0000; slave gives awready 3 cycles before wready → one clean completion with err 0.
- Misaligned: lw at 0x3001 → resp_err 1 one cycle after accept, no arvalid/awvalid ever asserted.
- Bus error: lhu with rresp=2'b10 → resp_err 2, resp_rdata 0. Store with bresp=2'b11 → resp_err 2.
- TIMEOUT=8, slave never raises arready → arvalid drops and resp_err 3 is reported exactly 8 cycles after entry to RD_ADDR. The next request is accepted normally.
- XLEN=64: ld at 0x4000 returns the full 64 bits; lwu at 0x4004 with rdata 0xFFFF_FFFF_0000_0000 → 0x0000_0000_FFFF_FFFF. Reset asserted while in WR_REQ → next edge all valids 0, IDLE, no resp_valid.
